// File: rtl/sprite_fetch_ctrl.sv
// sprite_fetch_ctrl: per-pixel read initiator for the character sprite frame
// ROMs plus the animation FSM that picks the frame offset once per video frame.
// Optional build macro: SPRITE_HFLIP_EN (facing_left mirrors the sprite column).
//
// state  | meaning
// STAND  | idle pose, frame 0
// WALK_A | walk cycle, first frame
// WALK_B | walk cycle, second frame
// PUNCH1 | punch wind-up (busy)
// PUNCH2 | punch follow-through (busy)
// DOWN   | crouch pose
// JUMP   | jump pose
// KICKED | hit reaction, held for HIT_TICKS (busy)
module sprite_fetch_ctrl #(
  parameter int unsigned SPR_W       = 250,
  parameter int unsigned SPR_H       = 200,
  parameter int unsigned FRAME_SIZE  = 50000,
  parameter int unsigned FRAME_BASE  = 0,
  parameter logic [3:0]  TRANSPARENT = 4'h0,
  parameter int unsigned ANIM_DIV    = 8,
  parameter int unsigned HIT_TICKS   = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  PosX,
  input  logic [9:0]  PosY,
  input  logic [2:0]  action,
  input  logic        facing_left,
  input  logic [3:0]  data_In,
  output logic [31:0] read_address,
  output logic [31:0] offset,
  output logic [3:0]  pix_index,
  output logic        pix_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    STAND  = 3'd0,
    WALK_A = 3'd1,
    WALK_B = 3'd2,
    PUNCH1 = 3'd3,
    PUNCH2 = 3'd4,
    DOWN   = 3'd5,
    JUMP   = 3'd6,
    KICKED = 3'd7
  } state_t;

  localparam logic [4:0] ANIM_LAST = 5'(ANIM_DIV - 1);
  localparam logic [4:0] HIT_LAST  = 5'(HIT_TICKS - 1);
  localparam logic [9:0] SPR_W_10  = 10'(SPR_W);
  localparam logic [9:0] SPR_H_10  = 10'(SPR_H);

  logic        fc_q, fc_prev_q, tick_q;
  logic        tick_w;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q;
  logic [31:0] offset_q;

  logic [10:0] rx_w, ry_w;
  logic        inside_w;
  logic [9:0]  col_w;
  logic [31:0] addr_w;
  logic [31:0] addr_q;
  logic        inside_d1_q, inside_d2_q;
  logic [3:0]  pix_index_q;
  logic        pix_valid_q;

  assign tick_w = fc_q & ~fc_prev_q;

  // frame_clk is registered, then its rising edge becomes a one-cycle tick;
  // tick_q marks the cycle after, when the new state is visible for offset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_q      <= 1'b0;
      fc_prev_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      fc_q      <= frame_clk;
      fc_prev_q <= fc_q;
      tick_q    <= tick_w;
    end
  end

  // next-state decode; the tick counter restarts on every state change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick_w) begin
      cnt_d = cnt_q + 5'd1;
      case (state_q)
        PUNCH1: begin
          if (action == 3'd5)          state_d = KICKED;
          else if (cnt_q == ANIM_LAST) state_d = PUNCH2;
        end
        PUNCH2: begin
          if (action == 3'd5)          state_d = KICKED;
          else if (cnt_q == ANIM_LAST) state_d = STAND;
        end
        KICKED: begin
          if (cnt_q == HIT_LAST)       state_d = STAND;
        end
        default: begin
          case (action)
            3'd5: state_d = KICKED;
            3'd2: state_d = PUNCH1;
            3'd3: state_d = DOWN;
            3'd4: state_d = JUMP;
            3'd1: begin
              if (state_q == WALK_A)
                state_d = (cnt_q == ANIM_LAST) ? WALK_B : WALK_A;
              else if (state_q == WALK_B)
                state_d = (cnt_q == ANIM_LAST) ? WALK_A : WALK_B;
              else
                state_d = WALK_A;
            end
            default: state_d = STAND;
          endcase
        end
      endcase
      if (state_d != state_q) cnt_d = 5'd0;
    end
  end

  // animation FSM registers with registered busy flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= STAND;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == PUNCH1) || (state_d == PUNCH2) || (state_d == KICKED);
    end
  end

  // frame offset only moves right after a tick so a frame never tears mid-screen
  always_ff @(posedge Clk) begin
    if (Reset)       offset_q <= FRAME_BASE;
    else if (tick_q) offset_q <= FRAME_BASE + 32'(state_q) * FRAME_SIZE;
  end

  // sprite-relative coordinates; bit 10 set means left/top overhang
  always_comb begin
    rx_w     = {1'b0, DrawX} - {1'b0, PosX};
    ry_w     = {1'b0, DrawY} - {1'b0, PosY};
    inside_w = !rx_w[10] && !ry_w[10] && (rx_w[9:0] < SPR_W_10) && (ry_w[9:0] < SPR_H_10);
`ifdef SPRITE_HFLIP_EN
    col_w    = facing_left ? (SPR_W_10 - 10'd1 - rx_w[9:0]) : rx_w[9:0];
`else
    col_w    = rx_w[9:0];
`endif
    addr_w   = 32'(ry_w[9:0]) * SPR_W + 32'(col_w);
  end

`ifndef SPRITE_HFLIP_EN
  logic unused_facing;
  assign unused_facing = facing_left;
`endif

  // three-stage pixel pipeline: address, ROM access, registered index/valid
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q      <= 32'd0;
      inside_d1_q <= 1'b0;
      inside_d2_q <= 1'b0;
      pix_index_q <= 4'd0;
      pix_valid_q <= 1'b0;
    end else begin
      addr_q      <= inside_w ? addr_w : 32'd0;
      inside_d1_q <= inside_w;
      inside_d2_q <= inside_d1_q;
      pix_index_q <= inside_d2_q ? data_In : 4'd0;
      pix_valid_q <= inside_d2_q && (data_In != TRANSPARENT);
    end
  end

  assign read_address = addr_q;
  assign offset       = offset_q;
  assign pix_index    = pix_index_q;
  assign pix_valid    = pix_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Scoreboard bench for sprite_fetch_ctrl: stimulus pushes expected values
// tagged with the cycle they are due; a negedge monitor pops and compares.
module tb_sprite_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [9:0]  DrawX, DrawY, PosX, PosY;
  logic [2:0]  action;
  logic        facing_left;
  logic [3:0]  data_In = 4'h0;
  logic [31:0] read_address, offset;
  logic [3:0]  pix_index;
  logic        pix_valid, busy;

  sprite_fetch_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .PosX(PosX), .PosY(PosY),
    .action(action), .facing_left(facing_left), .data_In(data_In),
    .read_address(read_address), .offset(offset),
    .pix_index(pix_index), .pix_valid(pix_valid), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // ROM stand-in: one-clock latency, content = (address + 5) mod 16
  always @(posedge Clk) data_In <= 4'(read_address + 32'd5);

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  localparam int K_ADDR = 0, K_IDX = 1, K_VAL = 2, K_OFF = 3, K_BUSY = 4;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic done_req = 1'b0;

  function automatic string kname(input int k);
    case (k)
      K_ADDR:  return "read_address";
      K_IDX:   return "pix_index";
      K_VAL:   return "pix_valid";
      K_OFF:   return "offset";
      default: return "busy";
    endcase
  endfunction

  function automatic void push(input int due, input int kind, input logic [31:0] v);
    exp_t e;
    e.due = due; e.kind = kind; e.exp = v;
    sb.push_back(e);
  endfunction

  // monitor: compare every entry that has come due; on drain request flag leftovers
  always @(negedge Clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (done_req || sb[i].due <= cyc) begin
        case (sb[i].kind)
          K_ADDR:  act = read_address;
          K_IDX:   act = {28'd0, pix_index};
          K_VAL:   act = {31'd0, pix_valid};
          K_OFF:   act = offset;
          default: act = {31'd0, busy};
        endcase
        checks = checks + 1;
        if (done_req || sb[i].due < cyc) begin
          errors = errors + 1;
          $display("FAIL %s at cycle %0d: check due cycle %0d never reached, required %0d",
                   kname(sb[i].kind), cyc, sb[i].due, sb[i].exp);
        end else if (act !== sb[i].exp) begin
          errors = errors + 1;
          $display("FAIL %s at cycle %0d: got %0d, required %0d",
                   kname(sb[i].kind), cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i = i + 1;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // one pixel per clock: address due next cycle, index/valid three cycles later
  task automatic pix(input int dx, input int dy, input int px, input int py, input logic f,
                     input int ea, input int ev, input int ei);
    DrawX = 10'(dx); DrawY = 10'(dy); PosX = 10'(px); PosY = 10'(py); facing_left = f;
    push(cyc + 1, K_ADDR, 32'(ea));
    push(cyc + 3, K_VAL,  32'(ev));
    push(cyc + 3, K_IDX,  32'(ei));
    step();
  endtask

  logic [31:0] cur_off = 32'd0;

  // one frame_clk pulse; offset must hold until two cycles later, then take the new frame
  task automatic tick(input int exp_off, input logic exp_busy);
    frame_clk = 1'b1;
    push(cyc + 2, K_OFF, cur_off);
    push(cyc + 3, K_OFF, 32'(exp_off));
    push(cyc + 3, K_BUSY, {31'd0, exp_busy});
    step(); step();
    frame_clk = 1'b0;
    step(); step();
    cur_off = 32'(exp_off);
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; action = 3'd0; facing_left = 1'b0;
    DrawX = 10'd100; DrawY = 10'd50; PosX = 10'd100; PosY = 10'd50;
    step(); step();
    push(cyc, K_ADDR, 32'd0);
    push(cyc, K_IDX,  32'd0);
    push(cyc, K_VAL,  32'd0);
    push(cyc, K_OFF,  32'd0);
    push(cyc, K_BUSY, 32'd0);
    Reset = 1'b0;
    step();

    // pixel path, back to back
    pix(100, 50, 100, 50, 1'b0,     0, 1,  5);
    pix(349, 249, 100, 50, 1'b0, 49999, 1,  4);
    pix(350, 249, 100, 50, 1'b0,     0, 0,  0);
    pix(111, 50, 100, 50, 1'b0,    11, 0,  0);
    pix(99, 50, 100, 50, 1'b0,      0, 0,  0);
    pix(100, 49, 100, 50, 1'b0,     0, 0,  0);
    pix(349, 250, 100, 50, 1'b0,    0, 0,  0);
    pix(120, 60, 100, 50, 1'b0,  2520, 1, 13);
    pix(1000, 5, 900, 0, 1'b0,   1350, 1, 11);
    pix(10, 5, 900, 0, 1'b0,        0, 0,  0);
`ifdef SPRITE_HFLIP_EN
    pix(100, 50, 100, 50, 1'b1,   249, 1, 14);
    pix(349, 249, 100, 50, 1'b1, 49750, 1, 11);
`else
    pix(100, 50, 100, 50, 1'b1,     0, 1,  5);
    pix(349, 249, 100, 50, 1'b1, 49999, 1,  4);
`endif
    DrawX = 10'd0; DrawY = 10'd0; facing_left = 1'b0;
    step(); step(); step(); step();

    // walk: WALK_A and WALK_B alternate every 8 ticks
    action = 3'd1;
    for (int k = 1; k <= 17; k++)
      tick((((k - 1) / 8) % 2 == 0) ? 50000 : 100000, 1'b0);
    action = 3'd7;
    tick(0, 1'b0);

    // poses
    action = 3'd3; tick(250000, 1'b0);
    action = 3'd4; tick(300000, 1'b0);
    action = 3'd0; tick(0, 1'b0);

    // full punch: 8 ticks per phase, then stand
    action = 3'd2; tick(150000, 1'b1);
    action = 3'd0;
    for (int k = 2; k <= 8; k++)  tick(150000, 1'b1);
    for (int k = 9; k <= 16; k++) tick(200000, 1'b1);
    tick(0, 1'b0);

    // kicked preempts a punch and holds 16 ticks, ignoring action
    action = 3'd2; tick(150000, 1'b1);
    action = 3'd0;
    for (int k = 2; k <= 4; k++)  tick(150000, 1'b1);
    action = 3'd5; tick(350000, 1'b1);
    action = 3'd2;
    for (int k = 6; k <= 20; k++) tick(350000, 1'b1);
    action = 3'd0; tick(0, 1'b0);

    // reset in the middle of KICKED
    action = 3'd5; tick(350000, 1'b1);
    action = 3'd0; tick(350000, 1'b1);
    Reset = 1'b1;
    push(cyc + 1, K_OFF,  32'd0);
    push(cyc + 1, K_BUSY, 32'd0);
    step();
    Reset = 1'b0;
    step(); step();
    cur_off = 32'd0;
    tick(0, 1'b0);

    for (int n = 0; n < 20 && sb.size() > 0; n++) step();
    done_req = 1'b1;
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
